reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 8, data bits per register (legal 1..32).
REQ-002 Parameter DEPTH, default 8, number of registers (power of two, 2..32); AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 always reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1; when 1, a same-cycle write to a read address is forwarded to that read port.
REQ-005 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every register on reset and sync clear.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release takes effect on the next rising edge of clk.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 sclr  input  1  synchronous clear of all registers and dirty bits.
REQ-012 raddr_a / raddr_b  input  AW  read addresses, ports A and B.
REQ-013 rdata_a / rdata_b  output  WIDTH  registered read data, ports A and B.
REQ-014 dirty  output  DEPTH  bit i high when register i written since last reset or sclr.

Function
REQ-015 Write: we=1 at an edge loads wdata into reg[waddr] and sets dirty[waddr]; we=0 leaves storage and dirty unchanged.
REQ-016 Read latency exactly 1 cycle: rdata_x at edge N+1 reflects raddr_x sampled at edge N, with both ports independent.
REQ-017 Reads return storage contents as they were before edge N, except when REQ-018 applies.
REQ-018 With BYPASS=1, if we=1 and waddr==raddr_x at edge N, rdata_x after edge N equals wdata; with BYPASS=0 it equals the old contents.
REQ-019 ZERO_REG=1: writes to address 0 change neither storage nor dirty[0]; reads of address 0 return 0 on both ports, with or without bypass; dirty[0] is constant 0.
REQ-020 sclr=1 at an edge sets all registers to RESET_VAL (reg 0 to 0 if ZERO_REG) and clears all dirty bits.
REQ-021 sclr has priority over we in the same cycle; the write is discarded and no dirty bit is set.
REQ-022 With sclr=1, read outputs after that edge show the post-clear value (RESET_VAL, or 0 for reg 0 with ZERO_REG); bypass does not apply.
REQ-023 Both ports reading the same address, including the write address, return identical data.
REQ-024 Addresses are fully decoded; no out-of-range access exists because DEPTH = 2^AW.
REQ-025 Outputs are driven only from flops; no combinational path from any input to rdata_a, rdata_b or dirty.

Reset
REQ-026 While reset=0: all registers = RESET_VAL (reg 0 = 0 if ZERO_REG), rdata_a = rdata_b = 0, dirty = 0, regardless of clk.
REQ-027 Reset assertion mid-write aborts the write; no partial update is visible after release.
REQ-028 The first edge after release samples inputs normally; no extra dead cycle.

Verification
REQ-029 Reset then read: WIDTH=8, RESET_VAL=8'h5A, reset low 3 cycles then high; read A=3, B=7 -> next cycle rdata_a=rdata_b=8'h5A, dirty=8'h00.
REQ-030 Write/read latency: write 8'hC3 to reg 5, then read A=5 the next cycle -> rdata_a=8'hC3 one cycle later, dirty=8'h20.
REQ-031 Bypass: same edge we=1, waddr=2, wdata=8'h11, raddr_a=2, raddr_b=2 -> BYPASS=1 gives both 8'h11; BYPASS=0 gives both the prior value (RESET_VAL).
REQ-032 Zero register: ZERO_REG=1, write 8'hFF to reg 0, then read A=0 -> rdata_a=8'h00, dirty[0]=0; ZERO_REG=0 -> 8'hFF, dirty[0]=1.
REQ-033 sclr vs write: regs 1..7 hold data; same edge sclr=1, we=1, waddr=4, wdata=8'h77, raddr_a=4 -> rdata_a=RESET_VAL, all regs RESET_VAL, dirty=0.
REQ-034 Async reset mid-operation: drop reset between edges while we=1 -> rdata and dirty go to 0 without a clk edge; after release, reads of the target register return RESET_VAL.

Source files
------------

// File: rtl/reg_file.sv
// Parameterised multi-port register file: one write port, two registered read ports,
// optional hard-wired zero register, write-to-read forwarding and per-register dirty flags.
module reg_file #(
   parameter int              WIDTH     = 8,
   parameter int              DEPTH     = 8,
   parameter int              ZERO_REG  = 1,
   parameter int              BYPASS    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int             AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             sclr,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic [DEPTH-1:0] dirty
);

   logic [WIDTH-1:0] mem_q   [DEPTH];
   logic [WIDTH-1:0] mem_d   [DEPTH];
   logic [WIDTH-1:0] clr_val [DEPTH];
   logic [DEPTH-1:0] wr_sel;
   logic [DEPTH-1:0] dirty_q, dirty_d;
   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
   logic             wr_en;

   // Writes aimed at a hard-wired zero register are dropped before decode.
   assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         assign clr_val[gi] = ((ZERO_REG != 0) && (gi == 0)) ? '0 : RESET_VAL;
         assign wr_sel[gi]  = wr_en && (waddr == AW'(gi));

         always_comb begin
            mem_d[gi] = mem_q[gi];
            if (sclr) begin
               mem_d[gi] = clr_val[gi];
            end else if (wr_sel[gi]) begin
               mem_d[gi] = wdata;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               mem_q[gi] <= clr_val[gi];
            end else begin
               mem_q[gi] <= mem_d[gi];
            end
         end
      end
   endgenerate

   always_comb begin
      dirty_d = dirty_q | wr_sel;
      if (sclr) begin
         dirty_d = '0;
      end
      // mem_d already carries the forwarded write or the cleared value, so reading
      // it gives bypass behaviour; without bypass only a clear is made visible.
      if ((BYPASS != 0) || sclr) begin
         rdata_a_d = mem_d[raddr_a];
         rdata_b_d = mem_d[raddr_b];
      end else begin
         rdata_a_d = mem_q[raddr_a];
         rdata_b_d = mem_q[raddr_b];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dirty_q   <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         dirty_q   <= dirty_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;
   assign dirty   = dirty_q;

endmodule
